// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin owner lock for a single I2C controller port.
// A client keeps the bus for as long as it holds req. Command fields are muxed
// from the owner slice, and status strobes are gated back to the owner only.
// All sequencing advances on i2c_strobe ticks. The error flags are the
// exception: drop_err and timeout are updated every clock.
module i2c_arbiter #(
   parameter int N       = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            i2c_strobe,
   output logic            i2c_enable,
   output logic [7:0]      i2c_reg_addr,
   output logic [4:0]      i2c_reg_len,
   output logic [7:0]      i2c_reg_wrdata,
   output logic            i2c_reg_rdwr,
   input  logic            i2c_done,
   input  logic            i2c_read_done,
   input  logic            i2c_ack,
   input  logic [7:0]      i2c_reg_rddata,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   input  logic [N-1:0]    c_enable,
   input  logic [8*N-1:0]  c_reg_addr,
   input  logic [5*N-1:0]  c_reg_len,
   input  logic [8*N-1:0]  c_reg_wrdata,
   input  logic [N-1:0]    c_reg_rdwr,
   output logic [N-1:0]    c_done,
   output logic [N-1:0]    c_read_done,
   output logic [N-1:0]    c_ack,
   output logic            drop_err,
   output logic            timeout
);

   localparam int OW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state, state_nxt;
   logic [OW-1:0] owner, owner_nxt;
   logic [OW-1:0] last, last_nxt;
   logic [OW-1:0] pick, sel;
   logic [N-1:0]  gnt_nxt;
   logic          busy, busy_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          found, abort, illegal;
   logic          rddata_unused;

   // Read data goes to the clients directly, so the arbiter never looks at it.
   assign rddata_unused = ^i2c_reg_rddata;

   // Owner-slice mux. Slice 0 is selected in IDLE so the fields stay deterministic.
   assign sel            = (state == GRANT) ? owner : '0;
   assign i2c_enable     = (state == GRANT) & c_enable[sel];
   assign i2c_reg_addr   = c_reg_addr[int'(sel)*8 +: 8];
   assign i2c_reg_len    = c_reg_len[int'(sel)*5 +: 5];
   assign i2c_reg_wrdata = c_reg_wrdata[int'(sel)*8 +: 8];
   assign i2c_reg_rdwr   = c_reg_rdwr[sel];

   // Status is visible only to the owner. gnt is all-zero in IDLE.
   assign c_done      = {N{i2c_done}} & gnt;
   assign c_read_done = {N{i2c_read_done}} & gnt;
   assign c_ack       = {N{i2c_ack}} & gnt;

   // gnt is one-hot on the owner in GRANT, so any enable outside it is dropped.
   assign illegal = |(c_enable & ~gnt);

   // Round-robin search for the first requester, starting after the last owner.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         if (!found && req[(int'(last) + k) % N]) begin
            found = 1'b1;
            pick  = OW'((int'(last) + k) % N);
         end
      end
   end

   // Next-state logic: busy/watchdog tracking plus the grant/release FSM, strobe-gated.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      gnt_nxt   = gnt;
      busy_nxt  = busy;
      cnt_nxt   = cnt;
      abort     = 1'b0;
      if (i2c_strobe) begin
         // A forwarded enable starts a transaction (and restarts the watchdog)
         // even when a done arrives on the same tick.
         if (i2c_enable) begin
            busy_nxt = 1'b1;
            cnt_nxt  = '0;
         end else if (busy && i2c_done) begin
            busy_nxt = 1'b0;
            cnt_nxt  = '0;
         end else if (busy && (cnt == CW'(TIMEOUT - 1))) begin
            abort    = 1'b1;
            busy_nxt = 1'b0;
            cnt_nxt  = '0;
         end else if (busy) begin
            cnt_nxt = cnt + 1'b1;
         end
         case (state)
            IDLE: begin
               if (found) begin
                  owner_nxt = pick;
                  gnt_nxt   = N'(1) << pick;
                  state_nxt = GRANT;
               end
            end
            GRANT: begin
               if (abort || (!req[owner] && !busy)) begin
                  gnt_nxt   = '0;
                  last_nxt  = owner;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State registers. Error flags are sampled every clock.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         owner    <= '0;
         last     <= OW'(N - 1);
         gnt      <= '0;
         busy     <= 1'b0;
         cnt      <= '0;
         drop_err <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         last     <= last_nxt;
         gnt      <= gnt_nxt;
         busy     <= busy_nxt;
         cnt      <= cnt_nxt;
         drop_err <= drop_err | illegal;
         timeout  <= abort;
      end
   end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter (N=2, TIMEOUT=4).
module tb_i2c_arbiter;

   localparam int N = 2;

   logic          clk;
   logic          rstn;
   logic          i2c_strobe;
   logic          i2c_enable;
   logic [7:0]    i2c_reg_addr;
   logic [4:0]    i2c_reg_len;
   logic [7:0]    i2c_reg_wrdata;
   logic          i2c_reg_rdwr;
   logic          i2c_done, i2c_read_done, i2c_ack;
   logic [7:0]    i2c_reg_rddata;
   logic [N-1:0]  req, gnt, c_enable, c_reg_rdwr;
   logic [8*N-1:0] c_reg_addr, c_reg_wrdata;
   logic [5*N-1:0] c_reg_len;
   logic [N-1:0]  c_done, c_read_done, c_ack;
   logic          drop_err, timeout;

   int n_vec = 0;
   int n_bad = 0;

   i2c_arbiter #(.N(N), .TIMEOUT(4)) dut (
      .clk(clk), .rstn(rstn), .i2c_strobe(i2c_strobe),
      .i2c_enable(i2c_enable), .i2c_reg_addr(i2c_reg_addr), .i2c_reg_len(i2c_reg_len),
      .i2c_reg_wrdata(i2c_reg_wrdata), .i2c_reg_rdwr(i2c_reg_rdwr),
      .i2c_done(i2c_done), .i2c_read_done(i2c_read_done), .i2c_ack(i2c_ack),
      .i2c_reg_rddata(i2c_reg_rddata), .req(req), .gnt(gnt),
      .c_enable(c_enable), .c_reg_addr(c_reg_addr), .c_reg_len(c_reg_len),
      .c_reg_wrdata(c_reg_wrdata), .c_reg_rdwr(c_reg_rdwr),
      .c_done(c_done), .c_read_done(c_read_done), .c_ack(c_ack),
      .drop_err(drop_err), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock edge, optionally with a controller tick; returns 1 time unit after the edge.
   task automatic tick(input logic s);
      i2c_strobe = s;
      @(posedge clk);
      #1;
      i2c_strobe = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #2;
      rstn = 1'b1;
      #1;
   endtask

   initial begin
      rstn = 1'b0; i2c_strobe = 1'b0;
      i2c_done = 1'b0; i2c_read_done = 1'b0; i2c_ack = 1'b0; i2c_reg_rddata = 8'h00;
      req = '0; c_enable = '0; c_reg_rdwr = '0;
      c_reg_addr = '0; c_reg_len = '0; c_reg_wrdata = '0;

      // Reset state. Status inputs are driven high to prove the gating.
      #12;
      i2c_done = 1'b1; i2c_read_done = 1'b1; i2c_ack = 1'b1;
      #1;
      check("rst_gnt", gnt, 0);
      check("rst_en", i2c_enable, 0);
      check("rst_cdone", c_done, 0);
      check("rst_crd", c_read_done, 0);
      check("rst_cack", c_ack, 0);
      check("rst_drop", drop_err, 0);
      check("rst_tmo", timeout, 0);
      i2c_done = 1'b0; i2c_read_done = 1'b0; i2c_ack = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;

      // Single client: a non-strobe edge must not grant.
      req = 2'b01;
      tick(1'b0);
      check("t1_nostrobe_gnt", gnt, 2'b00);
      tick(1'b1);
      check("t1_gnt", gnt, 2'b01);
      // Write: ptr 0xF4, len 3, data 0x5A.
      c_reg_addr[7:0] = 8'hF4; c_reg_len[4:0] = 5'd3; c_reg_wrdata[7:0] = 8'h5A; c_reg_rdwr[0] = 1'b0;
      c_reg_addr[15:8] = 8'h11; c_reg_len[9:5] = 5'd7; c_reg_wrdata[15:8] = 8'h22;
      c_enable = 2'b01;
      #1;
      check("t1_en", i2c_enable, 1);
      check("t1_addr", i2c_reg_addr, 8'hF4);
      check("t1_len", i2c_reg_len, 5'd3);
      check("t1_wdata", i2c_reg_wrdata, 8'h5A);
      check("t1_rdwr_w", i2c_reg_rdwr, 0);
      tick(1'b1);
      c_enable = 2'b00;
      i2c_done = 1'b1; i2c_ack = 1'b1;
      #1;
      check("t1_cdone_w", c_done, 2'b01);
      check("t1_cack_w", c_ack, 2'b01);
      tick(1'b1);
      i2c_done = 1'b0; i2c_ack = 1'b0;
      // Read: len 4.
      c_reg_len[4:0] = 5'd4; c_reg_rdwr[0] = 1'b1;
      c_enable = 2'b01;
      #1;
      check("t1_len_r", i2c_reg_len, 5'd4);
      check("t1_rdwr_r", i2c_reg_rdwr, 1);
      tick(1'b1);
      c_enable = 2'b00;
      i2c_read_done = 1'b1;
      #1;
      check("t1_crd", c_read_done, 2'b01);
      i2c_read_done = 1'b0;
      i2c_done = 1'b1;
      #1;
      check("t1_cdone_r", c_done, 2'b01);
      tick(1'b1);
      i2c_done = 1'b0;
      req = 2'b00;
      tick(1'b1);
      check("t1_release", gnt, 2'b00);
      check("t1_fields_idle", i2c_reg_addr, 8'hF4);

      // Contention from reset: client 0 first, then client 1 after a one-tick gap.
      do_reset();
      check("t2_rst_gnt", gnt, 2'b00);
      req = 2'b11;
      tick(1'b1);
      check("t2_gnt0", gnt, 2'b01);
      req = 2'b10;
      tick(1'b1);
      check("t2_gap", gnt, 2'b00);
      tick(1'b1);
      check("t2_gnt1", gnt, 2'b10);
      #1;
      check("t2_addr1", i2c_reg_addr, 8'h11);
      req = 2'b01;
      tick(1'b1);
      check("t2_rel1", gnt, 2'b00);
      req = 2'b11;
      tick(1'b1);
      check("t2_rr_gnt0", gnt, 2'b01);

      // Atomicity: owner busy, drops req; release waits for done.
      c_enable = 2'b01;
      tick(1'b1);
      c_enable = 2'b00;
      req = 2'b10;
      tick(1'b1);
      check("t3_hold_a", gnt, 2'b01);
      // Illegal enable from client 1.
      c_enable = 2'b10;
      #1;
      check("t3_illegal_en", i2c_enable, 0);
      tick(1'b0);
      c_enable = 2'b00;
      check("t3_drop_err", drop_err, 1);
      tick(1'b1);
      check("t3_hold_b", gnt, 2'b01);
      // Done and a new enable on the same tick: busy stays set.
      i2c_done = 1'b1; c_enable = 2'b01;
      #1;
      check("t3_cdone_owner", c_done, 2'b01);
      tick(1'b1);
      c_enable = 2'b00;
      check("t3_collide_hold", gnt, 2'b01);
      tick(1'b1);
      i2c_done = 1'b0;
      check("t3_done_hold", gnt, 2'b01);
      tick(1'b1);
      check("t3_release", gnt, 2'b00);
      tick(1'b1);
      check("t3_gnt1", gnt, 2'b10);
      check("t3_drop_sticky", drop_err, 1);

      // Watchdog, TIMEOUT=4.
      do_reset();
      check("t4_drop_clr", drop_err, 0);
      req = 2'b01;
      tick(1'b1);
      check("t4_gnt", gnt, 2'b01);
      c_enable = 2'b01;
      tick(1'b1);
      c_enable = 2'b00;
      for (int s = 1; s <= 3; s++) begin
         tick(1'b1);
         check("t4_no_tmo", timeout, 0);
         check("t4_still_gnt", gnt, 2'b01);
      end
      tick(1'b1);
      check("t4_tmo", timeout, 1);
      check("t4_tmo_rel", gnt, 2'b00);
      tick(1'b0);
      check("t4_tmo_pulse", timeout, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_arbiter.md
# i2c_arbiter

Round-robin arbiter that shares one I2C controller transaction port between N sensor clients (BMP280 interface and similar). Each client holds a level request for the duration of a multi-transaction sequence (pointer write + burst read). The arbiter locks the bus to that client, muxes its command fields to the controller, and routes completion/read strobes back only to the owner. It sits between the sensor interface modules and the single I2C controller, advancing only on controller `i2c_strobe` ticks.

## Interface
- `N`, 2: number of clients (2..8).
- `TIMEOUT`, 1023: max strobe ticks a transaction may stay outstanding before forced abort.
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `i2c_strobe` in 1: controller tick; broadcast unchanged to all clients.
- `i2c_enable` out 1: forwarded owner enable.
- `i2c_reg_addr` out 8, `i2c_reg_len` out 5, `i2c_reg_wrdata` out 8, `i2c_reg_rdwr` out 1: owner command fields.
- `i2c_done`, `i2c_read_done`, `i2c_ack` in 1 each: controller status.
- `i2c_reg_rddata` in 8: read byte; broadcast to all clients.
- `req` in N: client i holds high for its whole sequence.
- `gnt` out N: one-hot grant, registered.
- `c_enable` in N; `c_reg_addr` in 8N; `c_reg_len` in 5N; `c_reg_wrdata` in 8N; `c_reg_rdwr` in N: packed client fields, client i at slice i.
- `c_done`, `c_read_done`, `c_ack` out N each: status gated to owner.
- `drop_err` out 1: sticky; a non-owner asserted `c_enable`.
- `timeout` out 1: one-cycle pulse on watchdog abort.

## Operation
- State and registers update only in cycles with `i2c_strobe`=1, except `drop_err` and `timeout`.
- States:
  - IDLE: `gnt`=0. On strobe, if `req`≠0, pick the first requester searching from `last+1` (mod N), load `owner`, set `gnt[owner]`, go to GRANT.
  - GRANT: forward. On strobe with `!req[owner] && !busy`: clear `gnt`, set `last`=`owner`, go to IDLE. This leaves a mandatory one-tick gap before the next grant.
- Datapath is combinational from registered `owner`/state:
  - `i2c_enable` = GRANT & `c_enable[owner]`. Fields always mux the owner slice, or slice 0 in IDLE.
  - `c_done[i]` = `i2c_done` & `gnt[i]`. Same gating for `c_read_done` and `c_ack`.
- busy:
  - On strobe: set if `i2c_enable`; else clear if `i2c_done`. If both are high in the same strobe, busy=1 (back-to-back transaction).
  - Release is blocked while busy=1, even if `req` drops.
- Watchdog: counter increments on strobe while busy. Reaches `TIMEOUT` → busy=0, counter=0, `timeout` pulses, grant released as if `req` had dropped. The counter clears whenever busy clears.
- `drop_err` is set on any cycle with `c_enable[i]`=1 and (state≠GRANT or i≠`owner`). The enable is dropped and never forwarded. Cleared only by reset.
- Mid-sequence `req` changes from other clients have no effect until release.

## Timing
- Reset values: `gnt`=0, state IDLE, `owner`=0, `last`=N-1 (client 0 wins first), busy=0, counter=0, `drop_err`=0, `timeout`=0. `i2c_enable`=0 and all `c_*` outputs are 0.
- Grant latency: `req` high before strobe k → `gnt` high the cycle after strobe k.
- Enable/field forwarding and status gating add zero cycles.
- Release: first strobe with `!req[owner] && !busy` → `gnt`=0 the next cycle. Earliest new grant is the following strobe.
- Reset mid-sequence: all state returns to reset values immediately. The controller must be reset alongside.

## Test plan
- Single client: `req[0]`=1 → `gnt`=01 after first strobe. Write 0xF4/len 3, then read len 4. `c_done[0]` pulses twice, `c_done[1]` stays 0. Drop `req` → `gnt`=00.
- Contention: `req`=11 from reset → client 0 granted. After its release, client 1 is granted one strobe later. Reassert both → client 0 next (round-robin).
- Atomicity: client 0 owns with busy=1 and drops `req` → no release until `i2c_done`+strobe. `req[1]` waits.
- Done+enable collision: `i2c_done` and owner `c_enable` on the same strobe → busy remains 1 and there is no release.
- Illegal enable: client 1 pulses `c_enable` while client 0 owns → `i2c_enable` stays 0 and `drop_err`=1 until reset.
- Watchdog, `TIMEOUT`=4: enable forwarded, no `i2c_done` → `timeout` pulses after 4 busy strobes and the grant releases.
